prod_bcd_display: RTL and testbench

Sequential output stage downstream of the signed 4x4 Booth multiplier on the FPGA lab board. It captures the 8-bit signed product on request and converts its magnitude to three BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives the result, with a sign, onto a 4-digit multiplexed seven-segment display. The display always shows the last completed result, so a conversion in progress never disturbs it.

---
 rtl/prod_bcd_display.sv | 185 ++++++++++++++++++
 tb/tb_prod_bcd_display.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_bcd_display.sv
// Captures a signed 8-bit product, converts |product| to three BCD digits with an
// 8-iteration double-dabble engine, and scans sign + digits onto a 4-digit 7-seg display.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank leading zeros of hundreds/tens).
module prod_bcd_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  prod,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic        neg,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  mag_reg, mag_next;
    logic [11:0] scratch_reg, scratch_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        neg_r_reg, neg_r_next;
    logic [11:0] bcd_reg, bcd_next;
    logic        neg_reg, neg_next;
    logic        done_reg, done_next;

    logic [11:0] adj;
    logic [11:0] shifted;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                  ? scratch_reg[gi*4 +: 4] + 4'd3
                                  : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adj[10:0], mag_reg[7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mag_reg     <= 8'd0;
            scratch_reg <= 12'd0;
            cnt_reg     <= 3'd0;
            neg_r_reg   <= 1'b0;
            bcd_reg     <= 12'h000;
            neg_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mag_reg     <= mag_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            neg_r_reg   <= neg_r_next;
            bcd_reg     <= bcd_next;
            neg_reg     <= neg_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mag_next     = mag_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        neg_r_next   = neg_r_reg;
        bcd_next     = bcd_reg;
        neg_next     = neg_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    neg_r_next   = prod[7];
                    // -128 negates to 8'h80, which reads correctly as unsigned 128
                    mag_next     = prod[7] ? (~prod + 8'd1) : prod;
                    scratch_next = 12'd0;
                    cnt_next     = 3'd0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = shifted;
                mag_next     = {mag_reg[6:0], 1'b0};
                cnt_next     = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    bcd_next   = shifted;
                    neg_next   = neg_r_reg;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;
    assign neg  = neg_reg;

    logic [RW-1:0] refresh_reg, refresh_next;
    logic [1:0]    digit_reg, digit_next;
    logic [6:0]    seg_reg, seg_next;
    logic [3:0]    an_reg, an_next;
    logic          blank_h, blank_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    assign blank_h = (bcd_reg[11:8] == 4'd0);
    assign blank_t = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        refresh_next = refresh_reg + RW'(1);
        digit_next   = digit_reg;
        if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
            refresh_next = '0;
            digit_next   = digit_reg + 2'd1;
        end
    end

    // SEG/AN are computed for the digit that will be lit after this edge
    always_comb begin
        seg_next = SEG_BLANK;
        case (digit_next)
            2'd0:    seg_next = glyph(bcd_reg[3:0]);
            2'd1:    seg_next = blank_t ? SEG_BLANK : glyph(bcd_reg[7:4]);
            2'd2:    seg_next = blank_h ? SEG_BLANK : glyph(bcd_reg[11:8]);
            default: seg_next = neg_reg ? SEG_DASH : SEG_BLANK;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an_next[gi] = (digit_next != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg <= '0;
            digit_reg   <= 2'd0;
            seg_reg     <= 7'b1000000;
            an_reg      <= 4'b1110;
        end else begin
            refresh_reg <= refresh_next;
            digit_reg   <= digit_next;
            seg_reg     <= seg_next;
            an_reg      <= an_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_prod_bcd_display.sv
// Self-checking bench for prod_bcd_display: directed and random conversions against
// an arithmetic reference model, plus display scan checks with REFRESH_DIV = 4.
module tb_prod_bcd_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  prod = 8'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        neg;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;
    int last_mag = 0;
    bit last_neg = 1'b0;

    prod_bcd_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .prod  (prod),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; scan position follows from this alone
    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] model_bcd(input int mag);
        logic [11:0] r;
        r[11:8] = 4'(mag / 100);
        r[7:4]  = 4'((mag / 10) % 10);
        r[3:0]  = 4'(mag % 10);
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int d, input int mag, input bit ng);
        int h, t, o;
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (d)
            0: return glyph(o);
            1: begin
`ifdef LEAD_ZERO_BLANK_EN
                if (h == 0 && t == 0) return 7'b1111111;
`endif
                return glyph(t);
            end
            2: begin
`ifdef LEAD_ZERO_BLANK_EN
                if (h == 0) return 7'b1111111;
`endif
                return glyph(h);
            end
            default: return ng ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_mag = 0;
        last_neg = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 6;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", bcd); end
        if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %b want 0", neg); end
        if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an got %b want 1110", an); end
        if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg got %b want 1000000", seg); end
        @(negedge clk);
        rst = 1'b0;
        last_mag = 0;
        last_neg = 1'b0;
        $display("reset: busy=%b done=%b bcd=%h an=%b seg=%b", busy, done, bcd, an, seg);
    endtask

    // Starts a conversion in the current cycle; returns #1 after the DONE edge,
    // so a following call starts in the DONE cycle (back-to-back).
    task automatic test_convert(input logic [7:0] p);
        int mag;
        bit ng;
        logic [11:0] exp_bcd;
        ng  = p[7];
        mag = ng ? 256 - int'(p) : int'(p);
        exp_bcd = model_bcd(mag);
        @(negedge clk);
        prod  = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            prod = 8'($urandom);
            n_checks += 2;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL conv_busy p=%0d cyc=%0d got %b want 1", $signed(p), j, busy); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL conv_done_early p=%0d cyc=%0d got %b want 0", $signed(p), j, done); end
        end
        @(posedge clk);
        #1;
        n_checks += 4;
        if (done !== 1'b1) begin n_fail++; $display("FAIL conv_done p=%0d got %b want 1", $signed(p), done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL conv_busy_end p=%0d got %b want 0", $signed(p), busy); end
        if (bcd !== exp_bcd) begin n_fail++; $display("FAIL conv_bcd p=%0d got %h want %h", $signed(p), bcd, exp_bcd); end
        if (neg !== ng) begin n_fail++; $display("FAIL conv_neg p=%0d got %b want %b", $signed(p), neg, ng); end
        last_mag = mag;
        last_neg = ng;
        $display("convert: prod=%0d bcd=%h neg=%b done=%b", $signed(p), bcd, neg, done);
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        prod  = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) begin
                @(negedge clk);
                prod  = 8'hF8;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n_checks++;
            if (j < 8) begin
                if (done !== 1'b0) begin n_fail++; $display("FAIL ignore_done_early cyc=%0d got %b want 0", j, done); end
            end else begin
                if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b want 1", done); end
            end
        end
        n_checks += 2;
        if (bcd !== 12'h007) begin n_fail++; $display("FAIL ignore_bcd got %h want 007", bcd); end
        if (neg !== 1'b0) begin n_fail++; $display("FAIL ignore_neg got %b want 0", neg); end
        last_mag = 7;
        last_neg = 1'b0;
        $display("ignore_start: bcd=%h neg=%b", bcd, neg);
        test_convert(8'hF8);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        prod  = 8'h9D;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 6;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h want 000", bcd); end
        if (neg !== 1'b0) begin n_fail++; $display("FAIL abort_neg got %b want 0", neg); end
        if (an !== 4'b1110) begin n_fail++; $display("FAIL abort_an got %b want 1110", an); end
        if (seg !== 7'b1000000) begin n_fail++; $display("FAIL abort_seg got %b want 1000000", seg); end
        @(negedge clk);
        rst = 1'b0;
        last_mag = 0;
        last_neg = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0 || bcd !== 12'h000) begin
                n_fail++;
                $display("FAIL abort_no_done cyc=%0d done=%b bcd=%h want done=0 bcd=000", j, done, bcd);
            end
        end
        $display("reset_abort: busy=%b bcd=%h an=%b", busy, bcd, an);
    endtask

    task automatic test_rst_priority();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        prod  = 8'hFB;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        last_mag = 0;
        last_neg = 1'b0;
        for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
                n_fail++;
                $display("FAIL rst_priority cyc=%0d busy=%b done=%b bcd=%h want 0 0 000", j, busy, done, bcd);
            end
            @(posedge clk);
            #1;
        end
        $display("rst_priority: busy=%b done=%b bcd=%h", busy, done, bcd);
    endtask

    task automatic check_scan(input int cycles);
        int d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int j = 0; j < cycles; j++) begin
            @(posedge clk);
            #1;
            d = (tb_cyc / DIV) % 4;
            exp_an  = ~(4'b0001 << d);
            exp_seg = model_seg(d, last_mag, last_neg);
            n_checks += 2;
            if (an !== exp_an) begin n_fail++; $display("FAIL scan_an val=%0d cyc=%0d got %b want %b", last_mag, tb_cyc, an, exp_an); end
            if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg val=%0d digit=%0d got %b want %b", last_mag, d, seg, exp_seg); end
        end
    endtask

    task automatic test_display();
        do_reset();
        test_convert(8'hC8);
        check_scan(20);
        $display("display -56: an=%b seg=%b", an, seg);
        test_convert(8'd5);
        check_scan(20);
        $display("display 5: an=%b seg=%b", an, seg);
        test_convert(8'h80);
        check_scan(18);
        $display("display -128: an=%b seg=%b", an, seg);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            test_convert(8'($urandom));
            if ((i % 4) == 3) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_convert(8'd49);
        test_convert(8'hC8);
        test_convert(8'h80);
        test_convert(8'h00);
        test_convert(8'h7F);
        test_ignore_start();
        test_reset_abort();
        test_rst_priority();
        test_display();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
